// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file read arbiter: default widths,
// requester count and requester-id encoding.
package reg_file_pkg;

   localparam int AW_DEF  = 8;
   localparam int DW_DEF  = 48;
   localparam int NUM_REQ = 2;

   typedef enum logic {
      REQ_0 = 1'b0,
      REQ_1 = 1'b1
   } req_id_e;

   // Tag travelling alongside an issued read until its data returns.
   typedef struct packed {
      logic    vld;
      req_id_e id;
   } tag_t;

endpackage

// File: rtl/reg_file_rd_arb_if.sv
// Requester and register-file signals of the read arbiter, bundled with
// modports: slave = arbiter side, master = requesters + register file side.
interface reg_file_rd_arb_if #(
   parameter int aw = reg_file_pkg::AW_DEF,
   parameter int dw = reg_file_pkg::DW_DEF
) ();

   logic          Req_Valid_0, Req_Valid_1;
   logic [aw-1:0] Req_Addr_0,  Req_Addr_1;
   logic          Req_Ready_0, Req_Ready_1;
   logic          Rsp_Valid_0, Rsp_Valid_1;
   logic [dw-1:0] Rsp_Data_0,  Rsp_Data_1;
   logic          Mem_Rd_En;
   logic [aw-1:0] Mem_Rd_Addr;
   logic [dw-1:0] Mem_Rd_Data;

   modport slave (
      input  Req_Valid_0, Req_Valid_1, Req_Addr_0, Req_Addr_1, Mem_Rd_Data,
      output Req_Ready_0, Req_Ready_1, Rsp_Valid_0, Rsp_Valid_1,
             Rsp_Data_0, Rsp_Data_1, Mem_Rd_En, Mem_Rd_Addr
   );

   modport master (
      output Req_Valid_0, Req_Valid_1, Req_Addr_0, Req_Addr_1, Mem_Rd_Data,
      input  Req_Ready_0, Req_Ready_1, Rsp_Valid_0, Rsp_Valid_1,
             Rsp_Data_0, Rsp_Data_1, Mem_Rd_En, Mem_Rd_Addr
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way grant selection. Round-robin by default; macro
// REG_FILE_RD_ARB_FIXED_PRIO_EN switches to strict priority for requester 0.
module rr_arb2
   import reg_file_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_grant,
   output logic [NUM_REQ-1:0] gnt
);

`ifdef REG_FILE_RD_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      gnt = {req[1] & ~req[0], req[0]};
   end
`else
   // On contention the requester that did not win last time goes next.
   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = (last_grant == REQ_1) ? 2'b01 : 2'b10;
   end
`endif

endmodule

// File: rtl/reg_file_rd_arb.sv
// Two-requester read arbiter in front of a 1-cycle-latency register file.
// Arbitration mode selected by macro REG_FILE_RD_ARB_FIXED_PRIO_EN (in rr_arb2).
module reg_file_rd_arb
   import reg_file_pkg::*;
#(
   parameter int aw = AW_DEF,
   parameter int dw = DW_DEF
) (
   input  logic               Clock,
   input  logic               Reset_n,
   reg_file_rd_arb_if.slave   bus
);

   logic [NUM_REQ-1:0]         req, gnt_raw, gnt;
   logic                       accept;
   req_id_e                    acc_id;
   logic [aw-1:0]              rd_addr;

   logic                       last_grant_q, last_grant_d;
   tag_t                       tag_q, tag_d;
   logic [NUM_REQ-1:0]         rsp_vld_q, rsp_vld_d;
   logic [NUM_REQ-1:0][dw-1:0] rsp_data_q, rsp_data_d;

   assign req = {bus.Req_Valid_1, bus.Req_Valid_0};

   rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .gnt        (gnt_raw)
   );

   // Grants are suppressed while reset is held so nothing is accepted then.
   always_comb begin
      gnt     = Reset_n ? gnt_raw : '0;
      accept  = |gnt;
      acc_id  = gnt[1] ? REQ_1 : REQ_0;
      rd_addr = '0;
      if (gnt[0]) rd_addr = bus.Req_Addr_0;
      if (gnt[1]) rd_addr = bus.Req_Addr_1;
   end

   assign bus.Req_Ready_0 = gnt[0];
   assign bus.Req_Ready_1 = gnt[1];
   assign bus.Mem_Rd_En   = accept;
   assign bus.Mem_Rd_Addr = rd_addr;

   always_comb begin
      last_grant_d = accept ? logic'(acc_id) : last_grant_q;
      tag_d.vld    = accept;
      tag_d.id     = acc_id;
      rsp_data_d   = rsp_data_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_vld_d[i] = tag_q.vld && (int'(tag_q.id) == i);
         if (rsp_vld_d[i]) rsp_data_d[i] = bus.Mem_Rd_Data;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         last_grant_q <= REQ_1;
         tag_q        <= '0;
         rsp_vld_q    <= '0;
         rsp_data_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         tag_q        <= tag_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign bus.Rsp_Valid_0 = rsp_vld_q[0];
   assign bus.Rsp_Valid_1 = rsp_vld_q[1];
   assign bus.Rsp_Data_0  = rsp_data_q[0];
   assign bus.Rsp_Data_1  = rsp_data_q[1];

endmodule

// File: tb/tb_reg_file_rd_arb.sv
// Self-checking bench for reg_file_rd_arb: directed scenarios plus a randomized
// run against a transaction-level model. Honours REG_FILE_RD_ARB_FIXED_PRIO_EN.
module tb_reg_file_rd_arb;
   localparam int AW = 8;
   localparam int DW = 48;
`ifdef REG_FILE_RD_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset_n = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [DW-1:0] mem [256];

   always #5 Clock = ~Clock;

   reg_file_rd_arb_if #(.aw(AW), .dw(DW)) bus ();

   reg_file_rd_arb #(.aw(AW), .dw(DW)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // Register-file model: data valid the cycle after the read enable.
   always @(posedge Clock or negedge Reset_n)
      if (!Reset_n) bus.Mem_Rd_Data <= '0;
      else if (bus.Mem_Rd_En) bus.Mem_Rd_Data <= mem[bus.Mem_Rd_Addr];

   task automatic drive(input logic v0, input logic [AW-1:0] a0,
                        input logic v1, input logic [AW-1:0] a1);
      bus.Req_Valid_0 = v0; bus.Req_Addr_0 = a0;
      bus.Req_Valid_1 = v1; bus.Req_Addr_1 = a1;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      drive(0, 0, 0, 0);
      Reset_n = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      drive(1, 8'h11, 1, 8'h22);
      #1;
      vectors++;
      if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_En, bus.Mem_Rd_Addr,
           bus.Rsp_Valid_1, bus.Rsp_Valid_0, bus.Rsp_Data_0, bus.Rsp_Data_1} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdy=%b en=%b addr=%h rv=%b d0=%h d1=%h, want all 0",
                  {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_En, bus.Mem_Rd_Addr,
                  {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_0, bus.Rsp_Data_1);
      end
      @(negedge Clock);
      drive(0, 0, 0, 0);
      Reset_n = 1'b1;
   endtask

   task automatic test_single();
      logic [DW-1:0] exp_d;
      exp_d = 48'h0000_1234_5678;
      mem[8'h05] = exp_d;
      do_reset();
      drive(1, 8'h05, 0, 0);
      #1;
      vectors++;
      if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_En, bus.Mem_Rd_Addr} !== {2'b01, 1'b1, 8'h05}) begin
         miscompares++;
         $display("FAIL single_accept: rdy=%b en=%b addr=%h, want rdy=01 en=1 addr=05",
                  {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_En, bus.Mem_Rd_Addr);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clock);
         drive(0, 0, 0, 0);
         #1;
         vectors++;
         if ({bus.Rsp_Valid_1, bus.Rsp_Valid_0} !== ((k == 2) ? 2'b01 : 2'b00) ||
             (k == 2 && bus.Rsp_Data_0 !== exp_d)) begin
            miscompares++;
            $display("FAIL single_rsp_n%0d: rv=%b d0=%h, want rv=%b d0=%h", k + 0,
                     {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_0,
                     (k == 2) ? 2'b01 : 2'b00, exp_d);
         end
      end
   endtask

   task automatic test_contention();
      int            g [4];
      logic [AW-1:0] ad;
      logic [1:0]    exp_rv;
      mem[8'h10] = 48'hAAAA_0000_0010;
      mem[8'h20] = 48'hBBBB_0000_0020;
      for (int k = 0; k < 4; k++) g[k] = FIXED ? 0 : (k % 2);
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) drive(1, 8'h10, 1, 8'h20);
         else drive(0, 0, 0, 0);
         #1;
         if (k < 4) begin
            ad = (g[k] == 0) ? 8'h10 : 8'h20;
            vectors++;
            if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_En, bus.Mem_Rd_Addr} !==
                {(g[k] == 1), (g[k] == 0), 1'b1, ad}) begin
               miscompares++;
               $display("FAIL contention_grant_c%0d: rdy=%b addr=%h, want grant %0d addr=%h",
                        k, {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_Addr, g[k], ad);
            end
         end
         if (k >= 2) begin
            exp_rv = (g[k-2] == 0) ? 2'b01 : 2'b10;
            ad = (g[k-2] == 0) ? 8'h10 : 8'h20;
            vectors++;
            if ({bus.Rsp_Valid_1, bus.Rsp_Valid_0} !== exp_rv ||
                ((g[k-2] == 0) ? bus.Rsp_Data_0 : bus.Rsp_Data_1) !== mem[ad]) begin
               miscompares++;
               $display("FAIL contention_rsp_c%0d: rv=%b d0=%h d1=%h, want rv=%b data=%h",
                        k, {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_0,
                        bus.Rsp_Data_1, exp_rv, mem[ad]);
            end
         end
         @(negedge Clock);
      end
   endtask

   task automatic test_reset_mid();
      mem[8'h33] = 48'hDEAD_BEEF_0033;
      do_reset();
      drive(1, 8'h33, 0, 0);
      @(negedge Clock);
      drive(0, 0, 1, 8'h44);
      Reset_n = 1'b0;
      #1;
      vectors++;
      if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_En, bus.Mem_Rd_Addr,
           bus.Rsp_Valid_1, bus.Rsp_Valid_0, bus.Rsp_Data_0, bus.Rsp_Data_1} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: rdy=%b en=%b addr=%h rv=%b, want all 0",
                  {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_En, bus.Mem_Rd_Addr,
                  {bus.Rsp_Valid_1, bus.Rsp_Valid_0});
      end
      @(negedge Clock);
      drive(0, 0, 0, 0);
      Reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++;
         if ({bus.Rsp_Valid_1, bus.Rsp_Valid_0} !== 2'b00 || bus.Rsp_Data_0 !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_no_rsp_c%0d: rv=%b d0=%h, want rv=00 d0=0",
                     k, {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_0);
         end
         @(negedge Clock);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d0_keep;
      mem[8'h07] = 48'h0707_0707_0707;
      mem[8'hFF] = 48'hFFFF_0000_00FF;
      mem[8'h00] = 48'h0000_5555_0000;
      do_reset();
      drive(1, 8'h07, 0, 0);
      @(negedge Clock);
      drive(0, 0, 0, 0);
      @(negedge Clock);
      @(negedge Clock);
      d0_keep = 48'h0707_0707_0707;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) drive(0, 0, 1, 8'hFF);
         else if (k == 1) drive(0, 0, 1, 8'h00);
         else drive(0, 0, 0, 0);
         #1;
         if (k < 2) begin
            vectors++;
            if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_Addr} !==
                {2'b10, (k == 0) ? 8'hFF : 8'h00}) begin
               miscompares++;
               $display("FAIL b2b_accept_c%0d: rdy=%b addr=%h", k,
                        {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_Addr);
            end
         end
         if (k >= 2) begin
            vectors++;
            if (bus.Rsp_Valid_1 !== (k < 4) || bus.Rsp_Valid_0 !== 1'b0 ||
                (k < 4 && bus.Rsp_Data_1 !== mem[(k == 2) ? 8'hFF : 8'h00]) ||
                bus.Rsp_Data_0 !== d0_keep) begin
               miscompares++;
               $display("FAIL b2b_rsp_c%0d: rv=%b d1=%h d0=%h, want rv1=%b d0=%h",
                        k, {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_1,
                        bus.Rsp_Data_0, (k < 4), d0_keep);
            end
         end
         @(negedge Clock);
      end
   endtask

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   task automatic test_random();
      rsp_t          q[$];
      rsp_t          e;
      int            lg, g;
      logic          v0, v1;
      logic [AW-1:0] a0, a1, exp_addr;
      logic [1:0]    exp_rv;
      logic [DW-1:0] exp_d [2];
      lg = 1;
      exp_d[0] = '0;
      exp_d[1] = '0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         v0 = ($urandom_range(0, 9) < 6);
         v1 = ($urandom_range(0, 9) < 6);
         a0 = 8'($urandom);
         a1 = 8'($urandom);
         drive(v0, a0, v1, a1);
         #1;
         if (v0 && v1) g = FIXED ? 0 : 1 - lg;
         else if (v0) g = 0;
         else if (v1) g = 1;
         else g = -1;
         exp_addr = (g == 0) ? a0 : (g == 1) ? a1 : 8'h00;
         exp_rv = 2'b00;
         if (q.size() > 0 && q[0].due == c) begin
            e = q.pop_front();
            exp_rv[e.id] = 1'b1;
            exp_d[e.id] = e.data;
         end
         vectors++;
         if ({bus.Req_Ready_1, bus.Req_Ready_0, bus.Mem_Rd_En, bus.Mem_Rd_Addr} !==
             {(g == 1), (g == 0), (g >= 0), exp_addr}) begin
            miscompares++;
            $display("FAIL rand_grant_c%0d: rdy=%b en=%b addr=%h, want grant %0d addr=%h",
                     c, {bus.Req_Ready_1, bus.Req_Ready_0}, bus.Mem_Rd_En,
                     bus.Mem_Rd_Addr, g, exp_addr);
         end
         vectors++;
         if ({bus.Rsp_Valid_1, bus.Rsp_Valid_0} !== exp_rv ||
             bus.Rsp_Data_0 !== exp_d[0] || bus.Rsp_Data_1 !== exp_d[1]) begin
            miscompares++;
            $display("FAIL rand_rsp_c%0d: rv=%b d0=%h d1=%h, want rv=%b d0=%h d1=%h",
                     c, {bus.Rsp_Valid_1, bus.Rsp_Valid_0}, bus.Rsp_Data_0,
                     bus.Rsp_Data_1, exp_rv, exp_d[0], exp_d[1]);
         end
         if (g >= 0) begin
            q.push_back('{due: c + 2, id: g, data: mem[exp_addr]});
            lg = g;
         end
         @(negedge Clock);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'($urandom), 32'($urandom)};
      drive(0, 0, 0, 0);
      test_reset();
      test_single();
      test_contention();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
